// File: rtl/spi_inemo4.sv
// iNEMO-style SPI inertial sensor model (gyro yaw channel): 16-bit mode-0 register access plus periodic data-ready INT.
// Optional STATUS register at 0x1E enabled by defining SPI_INEMO4_STATUS_EN.
module spi_inemo4 #(
  parameter int unsigned INT_PERIOD   = 32768,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] YAW
);

  localparam int unsigned CNT_W = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam int unsigned BIT_W = 5;

  localparam logic [6:0] A_INT1_CTRL = 7'h0D;
  localparam logic [6:0] A_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] A_CTRL1     = 7'h10;
  localparam logic [6:0] A_CTRL2     = 7'h11;
  localparam logic [6:0] A_CTRL5     = 7'h14;
`ifdef SPI_INEMO4_STATUS_EN
  localparam logic [6:0] A_STATUS    = 7'h1E;
`endif
  localparam logic [6:0] A_OUTZ_L    = 7'h26;
  localparam logic [6:0] A_OUTZ_H    = 7'h27;

  logic r_ss_s1, r_ss_s2, r_ss_d;
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2;

  logic [15:0]      r_rx;
  logic [7:0]       r_tx;
  logic [BIT_W-1:0] r_bitcnt;
  logic             r_commit;

  logic [7:0]  r_int1_ctrl, r_ctrl1, r_ctrl2, r_ctrl5;
  logic [15:0] r_yaw_hold;
  logic [CNT_W-1:0] r_cnt;
  logic        r_dr_pend;
  logic        r_int;

  logic       w_ss_fall, w_ss_rise, w_ss_idle;
  logic       w_sclk_rise, w_sclk_fall;
  logic [6:0] w_rd_addr;
  logic [7:0] w_rd_byte;
  logic [6:0] w_c_addr;
  logic       w_c_read;
  logic       w_wrap, w_dr_fire, w_int_clr;

  // Two-flop synchronisers plus an edge-detect flop for SS_n and SCLK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= SS_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_ss_fall   = r_ss_d & ~r_ss_s2;
  assign w_ss_rise   = ~r_ss_d & r_ss_s2;
  assign w_ss_idle   = r_ss_d & r_ss_s2;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d & ~r_ss_s2;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d & ~r_ss_s2;

  // Address of the command byte as it completes on the 8th rise
  assign w_rd_addr = {r_rx[5:0], r_mosi_s2};

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_rd_addr)
      A_INT1_CTRL: w_rd_byte = r_int1_ctrl;
      A_WHO_AM_I:  w_rd_byte = WHO_AM_I_VAL;
      A_CTRL1:     w_rd_byte = r_ctrl1;
      A_CTRL2:     w_rd_byte = r_ctrl2;
      A_CTRL5:     w_rd_byte = r_ctrl5;
`ifdef SPI_INEMO4_STATUS_EN
      A_STATUS:    w_rd_byte = {6'b0, r_int, 1'b0};
`endif
      A_OUTZ_L:    w_rd_byte = r_yaw_hold[7:0];
      A_OUTZ_H:    w_rd_byte = r_yaw_hold[15:8];
      default:     w_rd_byte = 8'h00;
    endcase
  end

  // Shifters; tx holds its first data bit through the fall after the 8th rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx     <= '0;
      r_tx     <= '0;
      r_bitcnt <= '0;
    end else if (w_ss_fall) begin
      r_bitcnt <= '0;
      r_tx     <= '0;
    end else if (w_sclk_rise) begin
      r_rx <= {r_rx[14:0], r_mosi_s2};
      if (r_bitcnt != BIT_W'(16))
        r_bitcnt <= r_bitcnt + BIT_W'(1);
      if ((r_bitcnt == BIT_W'(7)) && r_rx[6])
        r_tx <= w_rd_byte;
    end else if (w_sclk_fall && (r_bitcnt >= BIT_W'(9))) begin
      r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign MISO = r_ss_s2 ? 1'bz : r_tx[7];

  assign w_c_addr  = r_rx[14:8];
  assign w_c_read  = r_rx[15];
  assign w_int_clr = r_commit & w_c_read & (w_c_addr == A_OUTZ_H);

  // Commit fires one clk after the synced SS_n rise of a complete 16-bit frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit    <= 1'b0;
      r_int1_ctrl <= 8'h00;
      r_ctrl1     <= 8'h00;
      r_ctrl2     <= 8'h00;
      r_ctrl5     <= 8'h00;
    end else begin
      r_commit <= w_ss_rise & (r_bitcnt == BIT_W'(16));
      if (r_commit && !w_c_read) begin
        case (w_c_addr)
          A_INT1_CTRL: r_int1_ctrl <= r_rx[7:0];
          A_CTRL1:     r_ctrl1     <= r_rx[7:0];
          A_CTRL2:     r_ctrl2     <= r_rx[7:0];
          A_CTRL5:     r_ctrl5     <= r_rx[7:0];
          default:     ;
        endcase
      end
    end
  end

  assign w_wrap    = r_int1_ctrl[1] & (r_cnt == CNT_W'(INT_PERIOD - 1));
  assign w_dr_fire = (w_wrap | r_dr_pend) & w_ss_idle;

  // Data-ready: capture is held off while a transaction is open so bytes never tear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dr_pend  <= 1'b0;
      r_yaw_hold <= '0;
      r_int      <= 1'b0;
    end else begin
      if (!r_int1_ctrl[1])
        r_cnt <= '0;
      else if (w_wrap)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      r_dr_pend <= (w_wrap | r_dr_pend) & ~w_ss_idle;

      if (w_dr_fire) begin
        r_yaw_hold <= YAW;
        r_int      <= 1'b1;
      end else if (w_int_clr) begin
        r_int <= 1'b0;
      end
    end
  end

  assign INT = r_int;

endmodule

// File: tb/tb_spi_inemo4.sv
// Scoreboard bench for spi_inemo4: randomized register traffic and data-ready timing against a transaction-level model.
module tb_spi_inemo4;

  localparam int TB_P = 4096;

  logic        clk, rst_n, SS_n, SCLK, MOSI;
  wire         MISO;
  logic        INT;
  logic [15:0] YAW;

  spi_inemo4 #(.INT_PERIOD(TB_P), .WHO_AM_I_VAL(8'h6A)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .YAW(YAW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       obs_valid = 1'b0;
  logic [7:0] obs_data = 8'h00;

  // Reference model state
  logic [7:0]  m_reg [0:127];
  logic [15:0] m_hold;
  logic        m_int;

  function automatic logic is_rw(input logic [6:0] a);
    return (a == 7'h0D) || (a == 7'h10) || (a == 7'h11) || (a == 7'h14);
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (is_rw(a)) return m_reg[a];
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h26) return m_hold[7:0];
    if (a == 7'h27) return m_hold[15:8];
`ifdef SPI_INEMO4_STATUS_EN
    if (a == 7'h1E) return {6'b0, m_int, 1'b0};
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
    m_hold = 16'h0000;
    m_int  = 1'b0;
  endtask

  // Monitor: pops the expected entry whenever an observation is presented
  initial begin
    exp_t e;
    forever begin
      @(posedge obs_valid);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_obs: got %02h, no expected entry", obs_data);
      end else begin
        e = sb_q.pop_front();
        if (obs_data !== e.exp) begin
          n_err++;
          $display("FAIL %s: got %02h, expected %02h", e.name, obs_data, e.exp);
        end
      end
    end
  end

  task automatic present(input string name, input logic [7:0] expv, input logic [7:0] act);
    exp_t e;
    e.name = name;
    e.exp  = expv;
    sb_q.push_back(e);
    obs_data  = act;
    obs_valid = 1'b1;
    #1;
    obs_valid = 1'b0;
    #1;
  endtask

  task automatic spi_xfer(input logic [15:0] w, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[15-i];
      repeat (8) @(negedge clk);
      if (i >= 8) rd = {rd[6:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_read(input logic [6:0] a);
    logic [7:0] rd;
    logic [7:0] expv;
    expv = model_read(a);
    spi_xfer({1'b1, a, 8'h00}, 16, rd);
    present($sformatf("read_%02h", a), expv, rd);
    if (a == 7'h27) m_int = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    spi_xfer({1'b0, a, d}, 16, rd);
    if (is_rw(a)) m_reg[a] = d;
  endtask

  task automatic check_int(input string name);
    @(negedge clk);
    present(name, {7'b0, m_int}, {7'b0, INT});
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [6:0]  alist [0:7];
    logic [6:0]  a;
    logic [7:0]  d, rd;
    logic [15:0] y1, y2;
    int          nb;

    alist[0] = 7'h0D; alist[1] = 7'h0F; alist[2] = 7'h10; alist[3] = 7'h11;
    alist[4] = 7'h14; alist[5] = 7'h1E; alist[6] = 7'h26; alist[7] = 7'h27;

    model_reset();
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    y1 = 16'($urandom);
    YAW = y1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check_int("int_after_reset");
    do_read(7'h0F);
    do_read(7'h10);
    do_read(7'h27);

    // Fixed writes from the register map, then randomized register traffic
    do_write(7'h11, 8'h60);
    do_read(7'h11);
    do_write(7'h0F, 8'h55);
    do_read(7'h0F);
    for (int n = 0; n < 14; n++) begin
      a = (n % 3 == 2) ? 7'($urandom_range(0, 127)) : alist[$urandom_range(0, 7)];
      d = 8'($urandom);
      if (a == 7'h0D) d = d & 8'hFD;
      do_write(a, d);
      do_read(a);
    end

    // Truncated write frames have no effect
    nb = 12;
    spi_xfer({1'b0, 7'h10, 8'h33}, nb, rd);
    do_read(7'h10);
    nb = $urandom_range(1, 15);
    spi_xfer({1'b0, 7'h14, ~m_reg[7'h14]}, nb, rd);
    do_read(7'h14);

    // Reset in the middle of a write frame
    fork
      spi_xfer({1'b0, 7'h11, 8'hA5}, 16, rd);
      begin
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    model_reset();
    do_read(7'h11);
    do_read(7'h0F);

    // Data-ready with the bus idle
    do_write(7'h0D, 8'h02);
    repeat (TB_P + 10) @(negedge clk);
    m_int = 1'b1; m_hold = y1;
    check_int("int_set");
    do_read(7'h26);
    check_int("int_kept_after_outz_l");
    do_read(7'h27);
    check_int("int_clr_after_outz_h");
    repeat (TB_P) @(negedge clk);
    m_int = 1'b1;
    check_int("int_set_again");
    do_read(7'h1E);
    check_int("int_kept_after_status");
    do_read(7'h27);
    check_int("int_clr_again");

    // Data-ready wrap in the middle of an OUTZ_H read
    do_write(7'h0D, 8'h00);
    y2 = 16'($urandom);
    YAW = y2;
    do_write(7'h0D, 8'h02);
    repeat (TB_P - 150) @(negedge clk);
    do_read(7'h27);
    m_int = 1'b1; m_hold = y2;
    check_int("int_collision_set_wins");
    do_read(7'h26);
    do_read(7'h27);
    check_int("int_clr_after_collision");

    repeat (20) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
